// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32I core front end.
//   NOP_INSTR  : bubble/flush encoding (addi x0,x0,0)
//   RESET_PC   : default PC after reset
//   if_state_t : fetch FSM states
//   word_align : clears the byte-offset bits of an address
package rv_core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } if_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response port (one outstanding request).
//   imem_req    : fetch request valid (master)
//   imem_addr   : word-aligned fetch address (master)
//   imem_gnt    : request accepted this cycle (slave)
//   imem_rvalid : imem_rdata valid, at least one cycle after gnt (slave)
//   imem_rdata  : fetched instruction (slave)
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock, asynchronous active-high reset
//   en         : 0 = hold both fields
//   load       : with en=1, capture instr_in/pc_in; otherwise insert NOP
//                and keep the PC field
//   instr_in, pc_in   : instruction and its PC from the fetch logic
//   instr_out, pc_out : registered IF/ID contents
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out <= NOP_INSTR;
            pc_out    <= RESET_PC;
        end else if (en) begin
            if (load) begin
                instr_out <= instr_in;
                pc_out    <= pc_in;
            end else begin
                // Bubble or flush: PC field keeps its last value.
                instr_out <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register.
//   clk, reset     : clock, asynchronous active-high reset
//   IFWrite        : 0 = hold PC and IF/ID (ID stall)
//   Branch, Jump   : redirect request from ID (ignored while IFWrite=0)
//   JumpAddr       : redirect target, low two bits dropped
//   imem           : instruction-memory master port (req/gnt/rvalid)
//   Instruction_id : IF/ID instruction
//   PC_id          : PC of Instruction_id
// Optional (IF_PERF_CNT_EN defined):
//   perf_fetch     : count of instructions delivered to ID
//   perf_bubble    : count of NOPs inserted (bubble or flush)
module if_stage #(
    parameter logic [31:0] RESET_PC  = rv_core_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    if_stage_if.master  imem,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`endif
);

    import rv_core_pkg::*;

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] pc_pend;
    logic [31:0] buf_data;
    logic        buf_vld;
    logic        kill;
    logic        req_q;

    logic        redirect;
    logic        gnt_ok;
    logic        deliver;
    logic [31:0] deliver_data;

    assign redirect = (Branch | Jump) & IFWrite;
    assign gnt_ok   = (state == FETCH) & req_q & imem.imem_gnt;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = word_align(pc);

    // Something valid reaches ID this edge: a live response or the buffer.
    always_comb begin
        deliver      = 1'b0;
        deliver_data = buf_data;
        if (IFWrite && !redirect) begin
            if (state == WAIT && imem.imem_rvalid && !kill) begin
                deliver      = 1'b1;
                deliver_data = imem.imem_rdata;
            end else if (state == HOLD && buf_vld) begin
                deliver = 1'b1;
            end
        end
    end

    // req_q is registered: it is set on every edge that leaves the FSM in
    // FETCH, so the first cycle after reset issues no request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= word_align(RESET_PC);
            pc_pend  <= word_align(RESET_PC);
            buf_data <= NOP_INSTR;
            buf_vld  <= 1'b0;
            kill     <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    req_q <= 1'b1;
                    if (gnt_ok) begin
                        pc_pend <= pc;
                        req_q   <= 1'b0;
                        state   <= WAIT;
                        // Redirect on the grant edge: the response is wrong-path.
                        kill    <= redirect;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        kill <= 1'b0;
                        if (kill || IFWrite) begin
                            // Delivered, flushed by redirect, or discarded.
                            state <= FETCH;
                            req_q <= 1'b1;
                        end else begin
                            buf_data <= imem.imem_rdata;
                            buf_vld  <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (IFWrite) begin
                        buf_vld <= 1'b0;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state <= FETCH;
                    req_q <= 1'b0;
                end
            endcase

            // Redirect wins over any same-edge delivery.
            if (redirect) begin
                pc      <= word_align(JumpAddr);
                buf_vld <= 1'b0;
            end else if (deliver) begin
                pc <= pc_pend + 32'd4;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR),
        .RESET_PC  (word_align(RESET_PC))
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .en        (IFWrite),
        .load      (deliver),
        .instr_in  (deliver_data),
        .pc_in     (pc_pend),
        .instr_out (Instruction_id),
        .pc_out    (PC_id)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch  <= 32'd0;
            perf_bubble <= 32'd0;
        end else begin
            if (deliver)
                perf_fetch <= perf_fetch + 32'd1;
            if (IFWrite && !deliver)
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFWrite, Branch, Jump;
    logic [31:0] JumpAddr;
    logic [31:0] Instruction_id, PC_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    if_stage_if imem();

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem           (imem),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch     (perf_fetch),
        .perf_bubble    (perf_bubble)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference model: transaction view of the fetch unit.
    logic [31:0] m_pc, m_instr, m_pcid;
    bit          m_out, m_kill, m_buf;
    logic [31:0] m_out_addr, m_buf_data, m_buf_addr;
    logic [31:0] m_fetch, m_bubble;
    int          idle_cnt;

    // Memory responder.
    bit          r_pend;
    int          r_cnt;
    logic [31:0] r_addr;

    // Stimulus knobs.
    int          p_ifw, p_redir, p_gnt, max_lat;
    bit          force_ja;
    logic [31:0] ja_val;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pcid = 32'h0;
        m_out = 0; m_kill = 0; m_buf = 0;
        m_out_addr = 0; m_buf_data = 0; m_buf_addr = 0;
        m_fetch = 0; m_bubble = 0; idle_cnt = 0;
        r_pend = 0; r_cnt = 0; r_addr = 0;
    endtask

    task automatic drive_idle();
        IFWrite = 0; Branch = 0; Jump = 0; JumpAddr = 0;
        imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = 0;
    endtask

    task automatic cycle();
        logic        s_req, g, rv, redir, dlv;
        logic [31:0] s_addr, ddata, daddr;
        bit          br;
        @(negedge clk);
        chk("instr_id", Instruction_id, m_instr);
        chk("pc_id", PC_id, m_pcid);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_bubble", perf_bubble, m_bubble);
`endif
        s_req  = imem.imem_req;
        s_addr = imem.imem_addr;
        if (s_req) chk("imem_addr", s_addr, m_pc);
        if (m_out || m_buf) chk("req_busy", {31'd0, s_req}, 32'd0);
        if (!m_out && !m_buf && !s_req) idle_cnt++; else idle_cnt = 0;
        if (idle_cnt >= 3) begin
            chk("req_idle", {31'd0, s_req}, 32'd1);
            idle_cnt = 0;
        end

        IFWrite  = ($urandom % 100) < p_ifw;
        br       = ($urandom % 100) < p_redir;
        Branch   = br & $urandom_range(0, 1);
        Jump     = br & ~Branch;
        JumpAddr = force_ja ? ja_val : $urandom;
        g        = s_req && (($urandom % 100) < p_gnt);
        imem.imem_gnt = g;
        rv = r_pend && (r_cnt == 0);
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rv ? mem_word(r_addr) : $urandom;
        if (r_pend && r_cnt > 0) r_cnt--;

        @(posedge clk);
        if (rv) r_pend = 0;
        if (g) begin
            r_pend = 1; r_addr = s_addr; r_cnt = $urandom_range(0, max_lat);
        end

        redir = (Branch | Jump) & IFWrite;
        dlv = 0; ddata = 0; daddr = 0;
        if (rv) begin
            if (!m_kill && !redir) begin
                if (IFWrite) begin
                    dlv = 1; ddata = imem.imem_rdata; daddr = m_out_addr;
                end else begin
                    m_buf = 1; m_buf_data = imem.imem_rdata; m_buf_addr = m_out_addr;
                end
            end
            m_out = 0; m_kill = 0;
        end else if (m_buf && IFWrite && !redir) begin
            dlv = 1; ddata = m_buf_data; daddr = m_buf_addr; m_buf = 0;
        end
        if (g) begin
            m_out = 1; m_out_addr = s_addr; m_kill = redir;
        end else if (m_out && redir) begin
            m_kill = 1;
        end
        if (redir) begin
            m_pc = JumpAddr & 32'hFFFF_FFFC; m_buf = 0;
        end else if (dlv) begin
            m_pc = daddr + 32'd4;
        end
        if (IFWrite) begin
            if (dlv) begin
                m_instr = ddata; m_pcid = daddr; m_fetch++;
            end else begin
                m_instr = NOP; m_bubble++;
            end
        end
    endtask

    task automatic run(input int n, input int ifw, input int rd, input int gp, input int lat);
        p_ifw = ifw; p_redir = rd; p_gnt = gp; max_lat = lat;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset asserted mid-cycle.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        drive_idle();
        model_reset();
        chk("rst_instr", Instruction_id, NOP);
        chk("rst_pc_id", PC_id, 32'h0);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1;
        drive_idle();
        model_reset();
        force_ja = 0; ja_val = 0;
        @(posedge clk);
        do_reset();

        // Reset while a fetch is outstanding, then zero-wait streaming.
        p_ifw = 100; p_redir = 0; p_gnt = 100; max_lat = 0;
        guard = 0;
        while (!m_out && guard < 20) begin cycle(); guard++; end
        chk("reach_wait", {31'd0, m_out}, 32'd1);
        @(posedge clk);
        do_reset();
        run(12, 100, 0, 100, 0);

        // ID stalls with buffered responses.
        run(80, 40, 0, 100, 2);
        // Redirects with varying memory latency.
        run(200, 90, 15, 80, 2);
        // Branch/Jump while stalled must be ignored.
        run(12, 0, 100, 100, 1);
        // Slow grant.
        run(100, 100, 0, 20, 3);

        // PC wrap at the top of the address space, then three flushes.
        force_ja = 1; ja_val = 32'hFFFF_FFFC;
        run(1, 100, 100, 0, 0);
        force_ja = 0;
        run(10, 100, 0, 100, 0);
        run(3, 100, 100, 100, 0);
        run(10, 100, 0, 100, 0);

        // Mixed random traffic with a reset in the middle.
        run(1000, 75, 10, 60, 3);
        do_reset();
        run(1000, 70, 8, 70, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
